// File: rtl/fir_ctrl_pkg.sv
// Shared types and widths for the FIR job controller.
// Holds the controller state encoding and default timing constants.
package fir_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LEN_W = 17;
    localparam int CLEAR_CYCLES_DEF = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/fir_run_ctrl_if.sv
// Core-side and RAM-side bus between the FIR core and its job controller.
// master = controller view, slave = core/RAM view.
interface fir_run_ctrl_if;
    import fir_ctrl_pkg::*;

    logic [ADDR_W-1:0] core_addr_rd_i;
    logic [ADDR_W-1:0] core_addr_wr_i;
    logic [DATA_W-1:0] core_dout_i;
    logic              core_we_i;
    logic              core_done_i;
    logic [ADDR_W-1:0] mem_addr_rd_o;
    logic [ADDR_W-1:0] mem_addr_wr_o;
    logic [DATA_W-1:0] mem_dout_o;
    logic              mem_we_o;

    modport master (
        input  core_addr_rd_i, core_addr_wr_i, core_dout_i,
        input  core_we_i, core_done_i,
        output mem_addr_rd_o, mem_addr_wr_o, mem_dout_o, mem_we_o
    );

    modport slave (
        output core_addr_rd_i, core_addr_wr_i, core_dout_i,
        output core_we_i, core_done_i,
        input  mem_addr_rd_o, mem_addr_wr_o, mem_dout_o, mem_we_o
    );

endinterface

// File: rtl/fir_run_wdog.sv
// Write-inactivity watchdog for the RUN state of the FIR job controller.
// expire flags the TIMEOUT_CYCLES-th consecutive RUN cycle without a core write.
module fir_run_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic we,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !run || we) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = run && !we && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fir_run_ctrl.sv
// Job controller for the FIR core: reset sequencing, address relocation, write gating.
// Define FIR_RUN_TIMEOUT_EN to add the RUN-state write-inactivity watchdog.
module fir_run_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] rd_base_i,
    input  logic [ADDR_W-1:0] wr_base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              irq_clr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  wr_cnt_o,
    output logic              core_rst_o,
    fir_run_ctrl_if.master    bus
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wr_cnt;
    logic [CW-1:0]     clr_cnt;
    logic              done;
    logic              err;
    logic              accept;
    logic              set_done;
    logic              set_err;
    logic              wr_ok;
    logic              last_wr;
    logic              expire;

    assign wr_ok   = bus.core_we_i && (state == RUN) && (wr_cnt < len);
    assign last_wr = wr_ok && ((wr_cnt + 1'b1) == len);

`ifdef FIR_RUN_TIMEOUT_EN
    fir_run_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk(clk),
        .rst(rst),
        .run(state == RUN),
        .we(bus.core_we_i),
        .expire(expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_wr) begin
                    state_nxt = DONE;
                end else if (bus.core_done_i || expire) begin
                    state_nxt = IDLE;
                    set_err   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                set_done  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides completion; the final write itself still goes out.
        if (abort_i && (state != IDLE)) begin
            state_nxt = IDLE;
            set_done  = 1'b0;
            set_err   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_base <= '0;
            wr_base <= '0;
            len     <= '0;
            wr_cnt  <= '0;
            clr_cnt <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            if (accept) begin
                rd_base <= rd_base_i;
                wr_base <= wr_base_i;
                len     <= len_i;
                wr_cnt  <= '0;
                done    <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                if (set_done) begin
                    done <= 1'b1;
                end else if (irq_clr_i) begin
                    done <= 1'b0;
                end
                if (set_err) begin
                    err <= 1'b1;
                end else if (irq_clr_i) begin
                    err <= 1'b0;
                end
            end
        end
    end

    assign busy_o     = (state != IDLE);
    assign core_rst_o = (state != RUN);
    assign done_o     = done;
    assign err_o      = err;
    assign wr_cnt_o   = wr_cnt;

    assign bus.mem_addr_rd_o = rd_base + bus.core_addr_rd_i;
    assign bus.mem_addr_wr_o = wr_base + bus.core_addr_wr_i;
    assign bus.mem_dout_o    = bus.core_dout_i;
    assign bus.mem_we_o      = wr_ok;

endmodule

// File: tb/tb_fir_run_ctrl.sv
// Self-checking bench for fir_run_ctrl: vector table, directed corner cases,
// and random traffic checked every cycle against a job-level reference model.
module tb_fir_run_ctrl;

    localparam int C = 2;
`ifdef FIR_RUN_TIMEOUT_EN
    localparam int T = 16;
`else
    localparam int T = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic        irq_clr_i;
    logic [15:0] rd_base_i;
    logic [15:0] wr_base_i;
    logic [16:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        core_rst_o;
    logic [16:0] wr_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fir_run_ctrl_if bus ();

    fir_run_ctrl #(
        .CLEAR_CYCLES(C),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .abort_i(abort_i),
        .rd_base_i(rd_base_i),
        .wr_base_i(wr_base_i),
        .len_i(len_i),
        .irq_clr_i(irq_clr_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .wr_cnt_o(wr_cnt_o),
        .core_rst_o(core_rst_o),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is "active" from acceptance until it ends;
    // the core runs once C clear cycles have elapsed and until the job finishes.
    bit          m_act, m_fin, m_done, m_err, m_w, m_r;
    int unsigned m_age, m_cnt, m_len;
    logic [15:0] m_rb, m_wb;
`ifdef FIR_RUN_TIMEOUT_EN
    int unsigned m_idle;
`endif

    function automatic bit m_run();
        return m_act && !m_fin && (m_age >= C);
    endfunction

    function automatic bit m_we();
        return (bus.core_we_i === 1'b1) && m_run() && (m_cnt < m_len);
    endfunction

    always @(posedge clk) begin
        m_w = m_we();
        m_r = m_run();
        if (rst) begin
            m_act = 0; m_fin = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_len = 0; m_age = 0; m_rb = '0; m_wb = '0;
        end else if (!m_act) begin
            if (start_i) begin
                m_act = 1; m_fin = 0; m_age = 0; m_cnt = 0;
                m_len = 32'(len_i); m_rb = rd_base_i; m_wb = wr_base_i;
                m_done = 0; m_err = 0;
            end else if (irq_clr_i) begin
                m_done = 0; m_err = 0;
            end
        end else begin
            if (irq_clr_i) begin
                m_done = 0; m_err = 0;
            end
            if (m_w) m_cnt++;
            if (abort_i) begin
                m_act = 0; m_err = 1;
            end else if (m_fin) begin
                m_act = 0; m_done = 1;
            end else if (!m_r) begin
                if (m_age == C - 1 && m_len == 0) m_fin = 1;
            end else if (m_w && m_cnt == m_len) begin
                m_fin = 1;
            end else if (bus.core_done_i) begin
                m_act = 0; m_err = 1;
`ifdef FIR_RUN_TIMEOUT_EN
            end else if (!bus.core_we_i && m_idle == T - 1) begin
                m_act = 0; m_err = 1;
`endif
            end
`ifdef FIR_RUN_TIMEOUT_EN
            m_idle = (m_r && !bus.core_we_i) ? m_idle + 1 : 0;
`endif
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy_o), 32'(m_act));
            chk("done", 32'(done_o), 32'(m_done));
            chk("err", 32'(err_o), 32'(m_err));
            chk("wr_cnt", 32'(wr_cnt_o), m_cnt);
            chk("core_rst", 32'(core_rst_o), 32'(!m_run()));
            chk("mem_we", 32'(bus.mem_we_o), 32'(m_we()));
            chk("mem_addr_rd", 32'(bus.mem_addr_rd_o), 32'(16'(m_rb + bus.core_addr_rd_i)));
            chk("mem_addr_wr", 32'(bus.mem_addr_wr_o), 32'(16'(m_wb + bus.core_addr_wr_i)));
            chk("mem_dout", 32'(bus.mem_dout_o), 32'(bus.core_dout_i));
        end
    end

    typedef struct {
        logic [15:0] rb;
        logic [15:0] wb;
        logic [16:0] len;
    } job_t;

    typedef struct {
        int          job;
        logic [15:0] ra;
        logic [15:0] wa;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        bit          exp_we;
    } vec_t;

    job_t jobs[2];
    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] rb, input logic [15:0] wb, input logic [16:0] len);
        start_i = 1'b1;
        rd_base_i = rb;
        wr_base_i = wb;
        len_i = len;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        jobs[0] = '{16'h1000, 16'h8000, 17'd4};
        jobs[1] = '{16'hFFF0, 16'hFFFE, 17'd3};
        vecs[0] = '{0, 16'h0000, 16'h0000, 16'h1000, 16'h8000, 1'b1};
        vecs[1] = '{0, 16'h0001, 16'h0001, 16'h1001, 16'h8001, 1'b1};
        vecs[2] = '{0, 16'h0002, 16'h0002, 16'h1002, 16'h8002, 1'b1};
        vecs[3] = '{0, 16'h0003, 16'h0003, 16'h1003, 16'h8003, 1'b1};
        vecs[4] = '{0, 16'h0004, 16'h0004, 16'h1004, 16'h8004, 1'b0};
        vecs[5] = '{1, 16'h0005, 16'h0000, 16'hFFF5, 16'hFFFE, 1'b1};
        vecs[6] = '{1, 16'h000F, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[7] = '{1, 16'h0010, 16'h0002, 16'h0000, 16'h0000, 1'b1};
        vecs[8] = '{1, 16'h0011, 16'h0003, 16'h0001, 16'h0001, 1'b0};

        rst = 1'b1;
        start_i = 0; abort_i = 0; irq_clr_i = 0;
        rd_base_i = '0; wr_base_i = '0; len_i = '0;
        bus.core_addr_rd_i = '0; bus.core_addr_wr_i = '0; bus.core_dout_i = '0;
        bus.core_we_i = 1'b0; bus.core_done_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
        chk_en = 1'b1;

        for (int j = 0; j < 2; j++) begin
            go(jobs[j].rb, jobs[j].wb, jobs[j].len);
            chk("tbl_busy", 32'(busy_o), 32'd1);
            chk("tbl_clear0", 32'(core_rst_o), 32'd1);
            step();
            chk("tbl_clear1", 32'(core_rst_o), 32'd1);
            step();
            chk("tbl_released", 32'(core_rst_o), 32'd0);
            for (int i = 0; i < 9; i++) begin
                if (vecs[i].job == j) begin
                    bus.core_we_i = 1'b1;
                    bus.core_addr_rd_i = vecs[i].ra;
                    bus.core_addr_wr_i = vecs[i].wa;
                    bus.core_dout_i = 16'($urandom);
                    #1;
                    chk("tbl_we", 32'(bus.mem_we_o), 32'(vecs[i].exp_we));
                    chk("tbl_addr_rd", 32'(bus.mem_addr_rd_o), 32'(vecs[i].exp_rd));
                    chk("tbl_addr_wr", 32'(bus.mem_addr_wr_o), 32'(vecs[i].exp_wr));
                    if (!vecs[i].exp_we) begin
                        chk("tbl_done_early", 32'(done_o), 32'd0);
                        chk("tbl_busy_in_done", 32'(busy_o), 32'd1);
                    end
                    step();
                end
            end
            bus.core_we_i = 1'b0;
            chk("tbl_done", 32'(done_o), 32'd1);
            chk("tbl_idle", 32'(busy_o), 32'd0);
            chk("tbl_cnt", 32'(wr_cnt_o), 32'(jobs[j].len));
        end

        bus.core_we_i = 1'b1;
        go(16'h0000, 16'h0000, 17'd0);
        step();
        step();
        chk("len0_rst", 32'(core_rst_o), 32'd1);
        chk("len0_busy", 32'(busy_o), 32'd1);
        chk("len0_we", 32'(bus.mem_we_o), 32'd0);
        step();
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_cnt", 32'(wr_cnt_o), 32'd0);
        chk("len0_idle", 32'(busy_o), 32'd0);
        bus.core_we_i = 1'b0;

        go(16'h0200, 16'h0300, 17'd8);
        step();
        step();
        bus.core_we_i = 1'b1;
        step();
        step();
        bus.core_we_i = 1'b0;
        start_i = 1'b1;
        len_i = 17'd1;
        step();
        start_i = 1'b0;
        chk("ign_busy", 32'(busy_o), 32'd1);
        chk("ign_cnt", 32'(wr_cnt_o), 32'd2);
        chk("ign_run", 32'(core_rst_o), 32'd0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_err", 32'(err_o), 32'd1);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_rst", 32'(core_rst_o), 32'd1);
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        chk("clr_err", 32'(err_o), 32'd0);

        go(16'h0040, 16'h0080, 17'd10);
        step();
        step();
        bus.core_we_i = 1'b1;
        repeat (3) step();
        bus.core_we_i = 1'b0;
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        chk("cdone_busy", 32'(busy_o), 32'd0);
        chk("cdone_err", 32'(err_o), 32'd1);
        chk("cdone_done", 32'(done_o), 32'd0);
        chk("cdone_cnt", 32'(wr_cnt_o), 32'd3);

`ifdef FIR_RUN_TIMEOUT_EN
        go(16'h0000, 16'h0000, 17'd5);
        step();
        step();
        repeat (T - 1) step();
        chk("wdog_still_busy", 32'(busy_o), 32'd1);
        step();
        chk("wdog_busy", 32'(busy_o), 32'd0);
        chk("wdog_err", 32'(err_o), 32'd1);
        chk("wdog_rst", 32'(core_rst_o), 32'd1);
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        chk("wdog_clr", 32'(err_o), 32'd0);
`endif

        go(16'h0100, 16'h0100, 17'd6);
        step();
        step();
        bus.core_we_i = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_core", 32'(core_rst_o), 32'd1);
        chk("mid_rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("mid_rst_cnt", 32'(wr_cnt_o), 32'd0);
        bus.core_we_i = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            start_i = ($urandom_range(3) == 0);
            rd_base_i = 16'($urandom);
            wr_base_i = 16'($urandom);
            len_i = ($urandom_range(15) == 0) ? 17'h10000 : 17'($urandom_range(6));
            abort_i = ($urandom_range(59) == 0);
            irq_clr_i = ($urandom_range(9) == 0);
            bus.core_we_i = 1'($urandom_range(1));
            bus.core_done_i = ($urandom_range(49) == 0);
            bus.core_addr_rd_i = 16'($urandom);
            bus.core_addr_wr_i = 16'($urandom);
            bus.core_dout_i = 16'($urandom);
            rst = ($urandom_range(499) == 0);
            step();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
